axil_arbiter: RTL and testbench

Two-requester AXI-Lite arbiter that shares the single AXI-Lite memory master port between instruction fetch (port 0, read-only) and the load/store unit (port 1, read/write, driven by the CPU memory interface).
- One transaction outstanding at a time, system-wide.
- Round-robin between ports on contention.
- The grant is held from address handshake until the response handshake completes.
- Sits between the CPU core and the RAM/peripheral interconnect.

---
 rtl/axil_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axil_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_arbiter.sv
// Two-requester AXI-Lite arbiter: instruction fetch (read-only) and load/store share one master port.
// One transaction in flight at a time; round-robin on contention; grant held until the response completes.
module axil_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  // port 0: instruction fetch, read only
  input  logic [ADDR_WIDTH-1:0]   s0_araddr,
  input  logic                    s0_arvalid,
  output logic                    s0_arready,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  output logic                    s0_rvalid,
  input  logic                    s0_rready,
  // port 1: load/store
  input  logic [ADDR_WIDTH-1:0]   s1_araddr,
  input  logic                    s1_arvalid,
  output logic                    s1_arready,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
  output logic                    s1_rvalid,
  input  logic                    s1_rready,
  input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic                    s1_awvalid,
  output logic                    s1_awready,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                    s1_wvalid,
  output logic                    s1_wready,
  output logic [1:0]              s1_bresp,
  output logic                    s1_bvalid,
  input  logic                    s1_bready,
  // shared master port
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [1:0]              o_Grant,
  output logic                    o_Busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   aw_done;
  logic   w_done;

  logic   req0;
  logic   req1;
  logic   wr_req;
  logic   grant;
  logic   aw_fin;
  logic   w_fin;

  assign req0   = s0_arvalid;
  assign wr_req = s1_awvalid && s1_wvalid;
  assign req1   = s1_arvalid || wr_req;
  // on a tie the port that did not win last time gets the bus
  assign grant  = (req0 && req1) ? ~last_grant : req1;
  assign aw_fin = aw_done || m_awready;
  assign w_fin  = w_done  || m_wready;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= grant;
            last_grant <= grant;
            state      <= (grant && wr_req) ? WR_ADDR : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (m_arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (m_rvalid && m_rready) state <= IDLE;
        end
        WR_ADDR: begin
          if (aw_fin && w_fin) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (m_awready) aw_done <= 1'b1;
            if (m_wready)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_bvalid && s1_bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // every handshake signal is a pure decode of state, so reset silences the bus at once
  always_comb begin
    s0_arready = 1'b0;
    s0_rdata   = '0;
    s0_rvalid  = 1'b0;
    s1_arready = 1'b0;
    s1_rdata   = '0;
    s1_rvalid  = 1'b0;
    s1_awready = 1'b0;
    s1_wready  = 1'b0;
    s1_bresp   = 2'b00;
    s1_bvalid  = 1'b0;
    m_araddr   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awaddr   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    case (state)
      RD_ADDR: begin
        m_arvalid = 1'b1;
        m_araddr  = owner ? s1_araddr : s0_araddr;
        if (owner) s1_arready = m_arready;
        else       s0_arready = m_arready;
      end
      RD_DATA: begin
        m_rready = owner ? s1_rready : s0_rready;
        if (owner) begin
          s1_rvalid = m_rvalid;
          s1_rdata  = m_rdata;
        end else begin
          s0_rvalid = m_rvalid;
          s0_rdata  = m_rdata;
        end
      end
      WR_ADDR: begin
        m_awvalid  = !aw_done;
        m_awaddr   = s1_awaddr;
        m_wvalid   = !w_done;
        m_wdata    = s1_wdata;
        m_wstrb    = s1_wstrb;
        s1_awready = m_awready && !aw_done;
        s1_wready  = m_wready && !w_done;
      end
      WR_RESP: begin
        m_bready  = s1_bready;
        s1_bvalid = m_bvalid;
        s1_bresp  = m_bresp;
      end
      default: ;
    endcase
  end

  assign o_Busy  = (state != IDLE);
  assign o_Grant = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_axil_arbiter.sv
// Bench for axil_arbiter: directed scenarios followed by randomized request mixes,
// with expected grants predicted by a round-robin model of pending requests.
module tb_axil_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic i_Clock = 1'b0;
  logic i_Reset = 1'b0;
  always #5 i_Clock = ~i_Clock;

  logic [AW-1:0] s0_araddr, s1_araddr, s1_awaddr, m_araddr, m_awaddr;
  logic s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [DW-1:0] s0_rdata, s1_rdata, s1_wdata, m_rdata, m_wdata;
  logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
  logic [DW/8-1:0] s1_wstrb, m_wstrb;
  logic [1:0] s1_bresp, m_bresp, o_Grant;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_bvalid, m_bready, o_Busy;

  int checks = 0;
  int failures = 0;
  bit model_last = 1'b1;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lat;
  } txn_t;

  axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .o_Grant(o_Grant), .o_Busy(o_Busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  // round-robin rule: a tie goes to the port that did not win last
  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && r1) return model_last ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  task automatic pulse_reset();
    i_Reset = 1'b0;
    #3;
    i_Reset = 1'b1;
    model_last = 1'b1;
    tick();
  endtask

  // Acts as the AXI-Lite slave for whichever transaction the arbiter issues next.
  task automatic slave_txn(input logic [31:0] rdata, input int la, input int lb,
                           input bit keep, output txn_t t);
    int n;
    int last_c;
    logic [1:0] br;
    n = 0;
    t = '{port: 0, wr: 1'b0, addr: 32'h0, data: 32'h0, strb: 4'h0, lat: 0};
    while (!(m_arvalid || m_awvalid) && n < 40) begin
      tick();
      n++;
    end
    t.lat = n;
    chk("txn_start", m_arvalid || m_awvalid, 1);
    if (!(m_arvalid || m_awvalid)) return;
    t.port = o_Grant[1] ? 1 : 0;
    chk("grant_onehot", $onehot(o_Grant), 1);
    chk("busy", o_Busy, 1);
    if (m_arvalid) begin
      t.wr = 1'b0;
      t.addr = m_araddr;
      for (int c = 0; c < la; c++) begin
        chk("arvalid_hold", m_arvalid, 1);
        tick();
      end
      m_arready = 1'b1;
      #1;
      chk("own_arready", t.port == 1 ? s1_arready : s0_arready, 1);
      chk("other_arready", t.port == 1 ? s0_arready : s1_arready, 0);
      tick();
      m_arready = 1'b0;
      if (!keep) begin
        if (t.port == 1) s1_arvalid = 1'b0;
        else s0_arvalid = 1'b0;
      end
      for (int c = 0; c < lb; c++) begin
        chk("rvalid_wait", t.port == 1 ? s1_rvalid : s0_rvalid, 0);
        tick();
      end
      m_rvalid = 1'b1;
      m_rdata = rdata;
      #1;
      chk("own_rvalid", t.port == 1 ? s1_rvalid : s0_rvalid, 1);
      chk("own_rdata", t.port == 1 ? s1_rdata : s0_rdata, rdata);
      chk("other_rvalid", t.port == 1 ? s0_rvalid : s1_rvalid, 0);
      chk("other_rdata", t.port == 1 ? s0_rdata : s1_rdata, 0);
      chk("m_rready", m_rready, 1);
      t.data = rdata;
      tick();
      m_rvalid = 1'b0;
      m_rdata = '0;
    end else begin
      t.wr = 1'b1;
      last_c = (la > lb) ? la : lb;
      for (int c = 0; c <= last_c; c++) begin
        m_awready = (c == la);
        m_wready = (c == lb);
        #1;
        chk("m_awvalid", m_awvalid, c <= la);
        chk("m_wvalid", m_wvalid, c <= lb);
        chk("s1_awready", s1_awready, c == la);
        chk("s1_wready", s1_wready, c == lb);
        chk("s0_arready_in_write", s0_arready, 0);
        if (c == la) t.addr = m_awaddr;
        if (c == lb) begin
          t.data = m_wdata;
          t.strb = m_wstrb;
        end
        tick();
      end
      m_awready = 1'b0;
      m_wready = 1'b0;
      if (!keep) begin
        s1_awvalid = 1'b0;
        s1_wvalid = 1'b0;
      end
      chk("wr_resp_awvalid", m_awvalid, 0);
      chk("wr_resp_bready", m_bready, 1);
      br = 2'($urandom_range(0, 3));
      m_bvalid = 1'b1;
      m_bresp = br;
      #1;
      chk("s1_bvalid", s1_bvalid, 1);
      chk("s1_bresp", s1_bresp, br);
      chk("s0_arready_in_resp", s0_arready, 0);
      tick();
      m_bvalid = 1'b0;
      m_bresp = 2'b00;
    end
  endtask

  task automatic expect_txn(input string tag, input txn_t t, input int port, input bit wr,
                            input logic [31:0] addr);
    chk({tag, "_port"}, t.port, port);
    chk({tag, "_kind"}, t.wr, wr);
    chk({tag, "_addr"}, t.addr, addr);
  endtask

  initial begin
    txn_t t;
    int exp_port;
    bit exp_wr;
    bit p0;
    logic [1:0] k1;
    bit pend0, pend1r, pend1w;
    logic [31:0] a0, a1, aw, wd, rd, ea;
    logic [3:0] ws;

    s0_araddr = '0; s0_arvalid = 0; s0_rready = 1;
    s1_araddr = '0; s1_arvalid = 0; s1_rready = 1;
    s1_awaddr = '0; s1_awvalid = 0; s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 0; s1_bready = 1;
    m_arready = 0; m_rdata = '0; m_rvalid = 0; m_awready = 0; m_wready = 0;
    m_bresp = 2'b00; m_bvalid = 0;

    // reset state
    #2;
    chk("rst_grant", o_Grant, 2'b00);
    chk("rst_busy", o_Busy, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    #10;
    i_Reset = 1'b1;
    tick();

    // single fetch read with slow data
    s0_araddr = 32'h0000_0100;
    s0_arvalid = 1'b1;
    #1;
    chk("t1_idle_grant", o_Grant, 2'b00);
    exp_port = model_pick(1, 0); model_last = exp_port[0];
    slave_txn(32'hDEAD_BEEF, 0, 3, 0, t);
    expect_txn("t1", t, exp_port, 0, 32'h0000_0100);
    chk("t1_latency", t.lat, 1);
    chk("t1_end_grant", o_Grant, 2'b00);
    chk("t1_end_busy", o_Busy, 0);

    // continuous contention from reset alternates grants
    pulse_reset();
    s0_araddr = 32'h0000_00A0; s0_arvalid = 1'b1;
    s1_araddr = 32'h0000_00B0; s1_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_port = model_pick(1, 1); model_last = exp_port[0];
      chk("t2_expected_order", exp_port, i % 2);
      slave_txn(exp_port == 1 ? 32'h22 : 32'h11, 1, 1, 1, t);
      expect_txn("t2", t, exp_port, 0, exp_port == 1 ? 32'h0000_00B0 : 32'h0000_00A0);
      chk("t2_latency", t.lat, 1);
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    tick();

    // byte store, AW accepted at cycle 2 and W at cycle 4
    s1_awaddr = 32'h0000_0203; s1_awvalid = 1'b1;
    s1_wdata = 32'hAB00_0000; s1_wstrb = 4'b1000; s1_wvalid = 1'b1;
    exp_port = model_pick(0, 1); model_last = exp_port[0];
    slave_txn(32'h0, 2, 4, 0, t);
    expect_txn("t3", t, 1, 1, 32'h0000_0203);
    chk("t3_wdata", t.data, 32'hAB00_0000);
    chk("t3_wstrb", t.strb, 4'b1000);
    chk("t3_latency", t.lat, 1);

    // write and read from port 1 together: write goes first
    s1_awaddr = 32'h0000_0310; s1_awvalid = 1'b1;
    s1_wdata = 32'h1234_5678; s1_wstrb = 4'b1111; s1_wvalid = 1'b1;
    s1_araddr = 32'h0000_0300; s1_arvalid = 1'b1;
    exp_port = model_pick(0, 1); model_last = exp_port[0];
    slave_txn(32'h0, 1, 0, 0, t);
    expect_txn("t4_first", t, 1, 1, 32'h0000_0310);
    exp_port = model_pick(0, 1); model_last = exp_port[0];
    slave_txn(32'h5555_AAAA, 0, 1, 0, t);
    expect_txn("t4_second", t, 1, 0, 32'h0000_0300);
    chk("t4_latency", t.lat, 1);

    // port 0 arrives while a port 1 write is in flight
    s1_awaddr = 32'h0000_0500; s1_awvalid = 1'b1;
    s1_wdata = 32'h0BAD_F00D; s1_wstrb = 4'b0011; s1_wvalid = 1'b1;
    exp_port = model_pick(0, 1); model_last = exp_port[0];
    tick();
    s0_araddr = 32'h0000_0600; s0_arvalid = 1'b1;
    slave_txn(32'h0, 1, 2, 0, t);
    expect_txn("t5_write", t, 1, 1, 32'h0000_0500);
    exp_port = model_pick(1, 0); model_last = exp_port[0];
    slave_txn(32'h6666_0000, 0, 0, 0, t);
    expect_txn("t5_read", t, 0, 0, 32'h0000_0600);
    chk("t5_latency", t.lat, 1);

    // asynchronous reset while waiting for read data
    s0_araddr = 32'h0000_0400; s0_arvalid = 1'b1;
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0; s0_arvalid = 1'b0;
    #1;
    chk("t6_pre_rready", m_rready, 1);
    chk("t6_pre_busy", o_Busy, 1);
    chk("t6_pre_grant", o_Grant, 2'b01);
    #1;
    i_Reset = 1'b0;
    model_last = 1'b1;
    #1;
    chk("t6_rst_rready", m_rready, 0);
    chk("t6_rst_busy", o_Busy, 0);
    chk("t6_rst_grant", o_Grant, 2'b00);
    #2;
    i_Reset = 1'b1;
    tick();
    s0_araddr = 32'h0000_0404; s0_arvalid = 1'b1;
    exp_port = model_pick(1, 0); model_last = exp_port[0];
    slave_txn(32'hC0FF_EE00, 1, 2, 0, t);
    expect_txn("t6_after", t, 0, 0, 32'h0000_0404);

    // randomized request mixes against the round-robin model
    for (int it = 0; it < 20; it++) begin
      p0 = 1'($urandom_range(0, 1));
      k1 = 2'($urandom_range(0, 3));
      if (!p0 && k1 == 2'b00) p0 = 1'b1;
      a0 = $urandom; a1 = $urandom; aw = $urandom; wd = $urandom; ws = 4'($urandom);
      s0_araddr = a0; s1_araddr = a1; s1_awaddr = aw; s1_wdata = wd; s1_wstrb = ws;
      s0_arvalid = p0; s1_arvalid = k1[0]; s1_awvalid = k1[1]; s1_wvalid = k1[1];
      pend0 = p0; pend1r = k1[0]; pend1w = k1[1];
      while (pend0 || pend1r || pend1w) begin
        exp_port = model_pick(pend0, pend1r || pend1w);
        model_last = exp_port[0];
        exp_wr = (exp_port == 1) && pend1w;
        ea = (exp_port == 0) ? a0 : (exp_wr ? aw : a1);
        rd = $urandom;
        slave_txn(rd, $urandom_range(0, 3), $urandom_range(0, 3), 0, t);
        expect_txn("rnd", t, exp_port, exp_wr, ea);
        chk("rnd_latency", t.lat, 1);
        if (exp_wr) begin
          chk("rnd_wdata", t.data, wd);
          chk("rnd_wstrb", t.strb, ws);
          pend1w = 1'b0;
        end else if (exp_port == 1) begin
          pend1r = 1'b0;
        end else begin
          pend0 = 1'b0;
        end
      end
      chk("rnd_idle", o_Busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
